// File: rtl/cpu_regfile_if.sv
// cpu_regfile_if: control/ALU side bus of the architectural register block.
// Guard signals exist only when STACK_GUARD_EN is defined.
interface cpu_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              wr_en;
    logic [2:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        pc_op;
    logic [1:0]        pc_inc;
    logic [ADDR_W-1:0] pc_in;
    logic [1:0]        sp_op;
    logic [DATA_W-1:0] flag_mask;
    logic [DATA_W-1:0] flag_in;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] X;
    logic [DATA_W-1:0] Y;
    logic [DATA_W-1:0] SP;
    logic [DATA_W-1:0] PS;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] stack_addr;
`ifdef STACK_GUARD_EN
    logic              guard_clr;
    logic              stack_ovf;
    logic              stack_unf;
    modport master (
        output wr_en, wr_sel, wr_data, pc_op, pc_inc, pc_in, sp_op, flag_mask, flag_in, guard_clr,
        input  A, X, Y, SP, PS, PC, stack_addr, stack_ovf, stack_unf
    );
    modport slave (
        input  wr_en, wr_sel, wr_data, pc_op, pc_inc, pc_in, sp_op, flag_mask, flag_in, guard_clr,
        output A, X, Y, SP, PS, PC, stack_addr, stack_ovf, stack_unf
    );
`else
    modport master (
        output wr_en, wr_sel, wr_data, pc_op, pc_inc, pc_in, sp_op, flag_mask, flag_in,
        input  A, X, Y, SP, PS, PC, stack_addr
    );
    modport slave (
        input  wr_en, wr_sel, wr_data, pc_op, pc_inc, pc_in, sp_op, flag_mask, flag_in,
        output A, X, Y, SP, PS, PC, stack_addr
    );
`endif
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile: 6502-style A/X/Y/SP/PS/PC register block with stack addressing.
// Optional sticky stack over/underflow flags enabled by STACK_GUARD_EN.
module cpu_regfile #(
    parameter int                         DATA_W     = 8,
    parameter int                         ADDR_W     = 16,
    parameter logic [DATA_W-1:0]          SP_RESET   = 8'hFD,
    parameter logic [DATA_W-1:0]          PS_RESET   = 8'h34,
    parameter logic [ADDR_W-1:0]          PC_RESET   = 16'h0000,
    parameter logic [ADDR_W-DATA_W-1:0]   STACK_PAGE = 8'h01
) (
    input logic           clk,
    input logic           reset,
    cpu_regfile_if.slave  bus
);
    localparam logic [DATA_W-1:0] PS_B5 = DATA_W'(32);
    localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

    logic [DATA_W-1:0] a_q, a_d, x_q, x_d, y_q, y_d, sp_q, sp_d, ps_q, ps_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wr_a, wr_x, wr_y, wr_sp, wr_ps, push, pop;

    always_comb begin
        wr_a  = bus.wr_en && bus.wr_sel == 3'd0;
        wr_x  = bus.wr_en && bus.wr_sel == 3'd1;
        wr_y  = bus.wr_en && bus.wr_sel == 3'd2;
        wr_sp = bus.wr_en && bus.wr_sel == 3'd3;
        wr_ps = bus.wr_en && bus.wr_sel == 3'd4;
        // a direct SP write suppresses the stack operation entirely
        push  = bus.sp_op == 2'b01 && !wr_sp;
        pop   = bus.sp_op == 2'b10 && !wr_sp;
        a_d   = wr_a ? bus.wr_data : a_q;
        x_d   = wr_x ? bus.wr_data : x_q;
        y_d   = wr_y ? bus.wr_data : y_q;
        sp_d  = wr_sp ? bus.wr_data : push ? sp_q - ONE : pop ? sp_q + ONE : sp_q;
        ps_d  = (wr_ps ? bus.wr_data : (ps_q & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask)) | PS_B5;
        pc_d  = bus.pc_op == 2'b01 ? pc_q + ADDR_W'(bus.pc_inc) :
                bus.pc_op == 2'b10 ? bus.pc_in : pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            x_q  <= '0;
            y_q  <= '0;
            sp_q <= SP_RESET;
            ps_q <= PS_RESET | PS_B5;
            pc_q <= PC_RESET;
        end else begin
            a_q  <= a_d;
            x_q  <= x_d;
            y_q  <= y_d;
            sp_q <= sp_d;
            ps_q <= ps_d;
            pc_q <= pc_d;
        end
    end

    // pop reads at SP+1, mirroring the 6502 pre-increment stack read
    assign bus.stack_addr = {STACK_PAGE, bus.sp_op == 2'b10 ? sp_q + ONE : sp_q};
    assign bus.A  = a_q;
    assign bus.X  = x_q;
    assign bus.Y  = y_q;
    assign bus.SP = sp_q;
    assign bus.PS = ps_q;
    assign bus.PC = pc_q;

`ifdef STACK_GUARD_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = (push && sp_q == '0) || (ovf_q && !bus.guard_clr);
        unf_d = (pop && sp_q == '1) || (unf_q && !bus.guard_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`endif
endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Parametrised successor to the 6502 softcore architectural register block. Holds A, X, Y, SP, PC and PS.
- Adds decoded register write select, PC increment/load, stack push/pop with stack-address generation, and masked flag updates.
- Sits between the control unit/ALU and the memory interface. All state changes on the clock edge; outputs are registered.

Parameters:
- DATA_W, 8, width of A, X, Y, SP, PS and wr_data.
- ADDR_W, 16, width of PC, pc_in and stack_addr; must equal STACK_PAGE width + DATA_W.
- SP_RESET, 8'hFD, SP value after reset.
- PS_RESET, 8'h34, PS value after reset.
- PC_RESET, 16'h0000, PC value after reset.
- STACK_PAGE, 8'h01, upper byte of stack_addr.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe.
- wr_sel  in  3  write target: 0=A, 1=X, 2=Y, 3=SP, 4=PS, 5-7 ignored.
- wr_data  in  DATA_W  write data.
- pc_op  in  2  00 hold, 01 PC+=pc_inc, 10 PC<=pc_in, 11 hold.
- pc_inc  in  2  increment amount 0-3.
- pc_in  in  ADDR_W  PC load value.
- sp_op  in  2  00 hold, 01 push (SP-1), 10 pop (SP+1), 11 hold.
- flag_mask  in  DATA_W  per-bit PS update enable.
- flag_in  in  DATA_W  new flag values.
- A, X, Y, SP, PS  out  DATA_W  registered architectural registers.
- PC  out  ADDR_W  registered program counter.
- stack_addr  out  ADDR_W  combinational stack address.

Behaviour:
- Synchronous reset: A=X=Y=0, SP=SP_RESET, PS=PS_RESET with bit 5 forced to 1, PC=PC_RESET.
- Reset overrides every other input in the same cycle. Reset asserted mid-push or mid-load discards that operation.
- Register write: wr_en=1 updates the selected register on the next edge (1-cycle latency). Unselected registers hold. wr_sel 5-7: no state change.
- PC:
  - op 01: PC <= PC + pc_inc, modulo 2^ADDR_W (FFFF+1 wraps to 0000). pc_inc=0 holds.
  - op 10: PC <= pc_in.
  - PC is independent of wr_en, so PC and a register write may occur in the same cycle.
- SP:
  - Push: SP <= SP-1, wrapping 00 to FF.
  - Pop: SP <= SP+1, wrapping FF to 00.
  - wr_en with wr_sel=3 in the same cycle as a push/pop: the write wins and sp_op is ignored.
- stack_addr:
  - Push: {STACK_PAGE, SP}, the pre-decrement SP.
  - Pop: {STACK_PAGE, SP+1}, matching 6502 pre-increment read.
  - Hold: {STACK_PAGE, SP}.
- PS:
  - Masked update: PS <= (PS & ~flag_mask) | (flag_in & flag_mask).
  - wr_en with wr_sel=4: full write wins and flag_mask is ignored.
  - Bit 5 reads 1 after every update, regardless of source.
- Simultaneous register write + masked flag update + push + PC increment are all legal and applied in one edge, subject to the priority rules above.
- No combinational path from inputs to the registered outputs. stack_addr is the only combinational output.

Optional Feature:
- Macro STACK_GUARD_EN.
- Defined:
  - Adds ports guard_clr (in, 1), stack_ovf (out, 1), stack_unf (out, 1).
  - Push while SP==0 sets stack_ovf; pop while SP==all-ones sets stack_unf. Both flags are sticky.
  - Cleared by reset or guard_clr=1. When guard_clr and a setting event coincide, the set wins.
  - Wrap arithmetic is unchanged.
- Undefined: the three ports and all guard logic are absent.

Test Plan:
- Reset -> A=X=Y=00, SP=FD, PS=34, PC=0000.
- wr_en=1, wr_sel=0, wr_data=5A -> A=5A next cycle, X/Y unchanged; then wr_sel=6 -> no register changes.
- PC=FFFE, pc_op=01, pc_inc=3 -> PC=0001; then pc_op=10, pc_in=C000 -> PC=C000.
- SP=00, push -> stack_addr=0100 during the cycle, SP=FF after; pop -> stack_addr=0100, SP=00. With STACK_GUARD_EN: the push sets stack_ovf; guard_clr=1 clears it.
- PS=34, flag_mask=C3, flag_in=81 -> PS=B5; wr_en=1, wr_sel=4, wr_data=00 with flag_mask=FF -> PS=20.
- wr_en=1, wr_sel=3, wr_data=40 with sp_op=01 -> SP=40. Reset asserted together with pc_op=10 -> PC=PC_RESET.
